ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per enabled cycle.
// Optional divider datapath is built only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module ex_muldiv #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic                 i_start,
  input  logic [2:0]           i_op,
  input  logic [BUS_WIDTH-1:0] i_bus_A,
  input  logic [BUS_WIDTH-1:0] i_bus_B,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BUS_WIDTH-1:0] o_hi,
  output logic [BUS_WIDTH-1:0] o_lo
);
  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [2*W-1:0] work_r, work_s, step_s, prod_s;
  logic [W-1:0]   opnd_r, opnd_s;
  logic           neg_lo_r, neg_lo_s;
  logic [W:0]     psum_s;
  logic [W-1:0]   res_hi_s, res_lo_s, hi_s, lo_s;
  logic           busy_s, done_s, sgn_s;
`ifdef MULDIV_DIV_EN
  logic           div_r, div_s, dz_r, dz_s, neg_hi_r, neg_hi_s;
  logic [W-1:0]   a_r, a_s;
  logic [W:0]     shifted_s, diff_s;
`endif

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  // One iteration: work_r holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    psum_s = {1'b0, work_r[2*W-1:W]} + (work_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    step_s = {psum_s, work_r[W-1:1]};
`ifdef MULDIV_DIV_EN
    shifted_s = work_r[2*W-1:W-1];
    diff_s    = shifted_s - {1'b0, opnd_r};
    if (div_r) begin
      if (!diff_s[W]) begin
        step_s = {diff_s[W-1:0], work_r[W-2:0], 1'b1};
      end else begin
        step_s = {shifted_s[W-1:0], work_r[W-2:0], 1'b0};
      end
    end else begin
      step_s = {psum_s, work_r[W-1:1]};
    end
`endif
  end

  // Final sign correction applied to the last step's value
  always_comb begin
    prod_s   = neg_lo_r ? -step_s : step_s;
    res_hi_s = prod_s[2*W-1:W];
    res_lo_s = prod_s[W-1:0];
`ifdef MULDIV_DIV_EN
    if (div_r) begin
      if (dz_r) begin
        res_lo_s = {W{1'b1}};
        res_hi_s = a_r;
      end else begin
        res_lo_s = neg_lo_r ? -step_s[W-1:0] : step_s[W-1:0];
        res_hi_s = neg_hi_r ? -step_s[2*W-1:W] : step_s[2*W-1:W];
      end
    end else begin
      res_lo_s = prod_s[W-1:0];
    end
`endif
  end

  // Next-state: flush aborts regardless of enable, disabled cycles hold everything but done
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    work_s   = work_r;
    opnd_s   = opnd_r;
    neg_lo_s = neg_lo_r;
    hi_s     = o_hi;
    lo_s     = o_lo;
    busy_s   = o_busy;
    done_s   = 1'b0;
    sgn_s    = ~i_op[0];
`ifdef MULDIV_DIV_EN
    div_s    = div_r;
    dz_s     = dz_r;
    neg_hi_s = neg_hi_r;
    a_s      = a_r;
`endif
    if (i_flush) begin
      state_s = IDLE;
      cnt_s   = {CW{1'b0}};
      busy_s  = 1'b0;
    end else if (!i_enable) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            case (i_op)
              3'b000, 3'b001: begin
                state_s  = BUSY;
                busy_s   = 1'b1;
                cnt_s    = CNT_LOAD;
                opnd_s   = mag(i_bus_A, sgn_s);
                work_s   = {{W{1'b0}}, mag(i_bus_B, sgn_s)};
                neg_lo_s = sgn_s & (i_bus_A[W-1] ^ i_bus_B[W-1]);
`ifdef MULDIV_DIV_EN
                div_s    = 1'b0;
                dz_s     = 1'b0;
                neg_hi_s = 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              3'b010, 3'b011: begin
                state_s  = BUSY;
                busy_s   = 1'b1;
                cnt_s    = CNT_LOAD;
                opnd_s   = mag(i_bus_B, sgn_s);
                work_s   = {{W{1'b0}}, mag(i_bus_A, sgn_s)};
                neg_lo_s = sgn_s & (i_bus_A[W-1] ^ i_bus_B[W-1]);
                neg_hi_s = sgn_s & i_bus_A[W-1];
                div_s    = 1'b1;
                dz_s     = (i_bus_B == {W{1'b0}});
                a_s      = i_bus_A;
              end
`endif
              3'b100:  hi_s = i_bus_A;
              3'b101:  lo_s = i_bus_A;
              default: state_s = IDLE;
            endcase
          end else begin
            state_s = IDLE;
          end
        end
        BUSY: begin
          work_s = step_s;
          cnt_s  = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            hi_s    = res_hi_s;
            lo_s    = res_lo_s;
          end else begin
            state_s = BUSY;
          end
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      work_r   <= {(2*W){1'b0}};
      opnd_r   <= {W{1'b0}};
      neg_lo_r <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_hi     <= {W{1'b0}};
      o_lo     <= {W{1'b0}};
`ifdef MULDIV_DIV_EN
      div_r    <= 1'b0;
      dz_r     <= 1'b0;
      neg_hi_r <= 1'b0;
      a_r      <= {W{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      work_r   <= work_s;
      opnd_r   <= opnd_s;
      neg_lo_r <= neg_lo_s;
      o_busy   <= busy_s;
      o_done   <= done_s;
      o_hi     <= hi_s;
      o_lo     <= lo_s;
`ifdef MULDIV_DIV_EN
      div_r    <= div_s;
      dz_r     <= dz_s;
      neg_hi_r <= neg_hi_s;
      a_r      <= a_s;
`endif
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random ops against an arithmetic model.
// Expectations for DIV/DIVU follow the MULDIV_DIV_EN build setting.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst, enable, flush, start;
  logic [2:0]  op;
  logic [31:0] bus_a, bus_b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] exp_hi, exp_lo;
  int          checks = 0;
  int          errors = 0;

  ex_muldiv #(.BUS_WIDTH(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_flush(flush), .i_start(start),
    .i_op(op), .i_bus_A(bus_a), .i_bus_B(bus_b),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: returns whether the op is iterative and the resulting HI/LO
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                    output logic it, output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    int sa, sb;
    it = 1'b0; rh = cur_hi; rl = cur_lo;
    sa = $signed(a); sb = $signed(b);
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); it = 1'b1; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; it = 1'b1; rh = p[63:32]; rl = p[31:0]; end
`ifdef MULDIV_DIV_EN
      3'd2: begin
        it = 1'b1;
        if (b == 32'd0) begin rl = 32'hFFFFFFFF; rh = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin rl = 32'h80000000; rh = 32'd0; end
        else begin rl = sa / sb; rh = sa % sb; end
      end
      3'd3: begin
        it = 1'b1;
        if (b == 32'd0) begin rl = 32'hFFFFFFFF; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
`endif
      3'd4: rh = a;
      3'd5: rl = a;
      default: it = 1'b0;
    endcase
  endfunction

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic it;
    logic [31:0] rh, rl;
    int n;
    ref_model(o, a, b, exp_hi, exp_lo, it, rh, rl);
    op = o; bus_a = a; bus_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (it) begin
      check("busy_rise", {31'd0, busy}, 32'd1);
      count_busy(n);
      check("latency", 32'(n), 32'd32);
      check("done_pulse", {31'd0, done}, 32'd1);
    end else begin
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("done_idle", {31'd0, done}, 32'd0);
    end
    exp_hi = rh; exp_lo = rl;
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
    tick();
    check("done_drop", {31'd0, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; flush = 1'b0; start = 1'b1; op = 3'd4;
    bus_a = 32'hDEADBEEF; bus_b = 32'd0;
    repeat (2) tick();
    rst = 1'b0; start = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;

    do_op(3'd4, 32'h12345678, 32'd0);
    do_op(3'd5, 32'h9ABCDEF0, 32'd0);
    do_op(3'd0, 32'hFFFFFFFE, 32'd3);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2);
    do_op(3'd3, 32'd7, 32'd0);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    do_op(3'd2, 32'h80000000, 32'd0);
    do_op(3'd0, 32'h80000000, 32'h80000000);

    // Enable held low for 10 cycles mid-operation
    op = 3'd1; bus_a = 32'd5; bus_b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    enable = 1'b0;
    repeat (10) tick();
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_lo", lo, exp_lo);
    enable = 1'b1;
    count_busy(n);
    check("stall_rest", 32'(n), 32'd28);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_prod_lo", lo, 32'd30);
    check("stall_prod_hi", hi, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd30;
    tick();

    // Flush mid-operation, with a start held during busy that must be ignored
    do_op(3'd4, 32'h11111111, 32'd0);
    do_op(3'd5, 32'h11111111, 32'd0);
    op = 3'd1; bus_a = $urandom; bus_b = $urandom; start = 1'b1;
    tick();
    op = 3'd5; bus_a = 32'h00000005;
    repeat (4) tick();
    start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_hi", hi, 32'h11111111);
    check("flush_lo", lo, 32'h11111111);
    tick();
    check("flush_done2", {31'd0, done}, 32'd0);
    do_op(3'd1, 32'd5, 32'd6);

    // Flush wins over a simultaneous start
    op = 3'd4; bus_a = 32'hCAFEF00D; start = 1'b1; flush = 1'b1;
    tick();
    op = 3'd0; bus_a = 32'd9; bus_b = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flwin_busy", {31'd0, busy}, 32'd0);
    check("flwin_hi", hi, exp_hi);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    // Reset in the middle of an operation
`ifdef MULDIV_DIV_EN
    op = 3'd3; bus_a = 32'd100; bus_b = 32'd7;
`else
    op = 3'd1; bus_a = 32'd100; bus_b = 32'd7;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    tick();
    check("mrst_done2", {31'd0, done}, 32'd0);
    do_op(3'd0, 32'hFFFFFFF9, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
